// File: rtl/alu_pkg.sv
// Shared definitions for the arithmetic-unit command initiator.
//   - op encodings driven onto ALU_FUN[1:0]
//   - FSM state encoding
//   - default operand and tag widths
package alu_pkg;

   localparam int unsigned DEF_WIDTH = 16;
   localparam int unsigned DEF_TAG_W = 4;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_MUL = 2'b10,
      OP_DIV = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_e;

endpackage

// File: rtl/alu_cmd_initiator.sv
// Initiator/collector for the 16-bit arithmetic unit. Accepts one operation on the
// request port, drives the unit for a single enable cycle, waits out the unit's
// registered latency, captures result/carry/flag and returns them with the request
// tag on the response port. One operation in flight at a time.
//
// Ports:
//   CLK, RST                     clock (rising edge), asynchronous active-high reset
//   REQ_VALID/REQ_READY          request handshake
//   REQ_A, REQ_B, REQ_OP, REQ_TAG  request payload (op: 00 add, 01 sub, 10 mul, 11 div)
//   ALU_A, ALU_B, ALU_FUN        operands and function to the unit (FUN[3:2] = 0)
//   Arith_Enable                 one-cycle issue strobe to the unit
//   Arith_OUT, Carry_OUT, Arith_Flag  unit result, carry and valid flag
//   RSP_VALID/RSP_READY          response handshake
//   RSP_DATA, RSP_CARRY, RSP_ERR, RSP_TAG  response payload
//
// Build option: define ALU_DIV_ZERO_CHECK_EN to answer divide-by-zero locally
// (all-ones data, error set) without issuing it to the unit.
module alu_cmd_initiator
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH   = DEF_WIDTH,
   parameter int unsigned TAG_W   = DEF_TAG_W,
   parameter int unsigned LATENCY = 1
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             REQ_VALID,
   output logic             REQ_READY,
   input  logic [WIDTH-1:0] REQ_A,
   input  logic [WIDTH-1:0] REQ_B,
   input  logic [1:0]       REQ_OP,
   input  logic [TAG_W-1:0] REQ_TAG,
   output logic [WIDTH-1:0] ALU_A,
   output logic [WIDTH-1:0] ALU_B,
   output logic [3:0]       ALU_FUN,
   output logic             Arith_Enable,
   input  logic [WIDTH-1:0] Arith_OUT,
   input  logic             Carry_OUT,
   input  logic             Arith_Flag,
   output logic             RSP_VALID,
   input  logic             RSP_READY,
   output logic [WIDTH-1:0] RSP_DATA,
   output logic             RSP_CARRY,
   output logic             RSP_ERR,
   output logic [TAG_W-1:0] RSP_TAG
);

   // Counter is loaded in ISSUE and reaches 0 in the cycle the unit result is valid.
   localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

   state_e           state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [TAG_W-1:0] tag_q, tag_d;

   logic             req_ready_d;
   logic [WIDTH-1:0] alu_a_d, alu_b_d;
   logic [3:0]       alu_fun_d;
   logic             arith_enable_d;
   logic             rsp_valid_d;
   logic [WIDTH-1:0] rsp_data_d;
   logic             rsp_carry_d;
   logic             rsp_err_d;
   logic [TAG_W-1:0] rsp_tag_d;

   logic             accept;
   logic             div_zero;

   assign accept = REQ_VALID & REQ_READY;

`ifdef ALU_DIV_ZERO_CHECK_EN
   assign div_zero = (REQ_OP == OP_DIV) && (REQ_B == '0);
`else
   assign div_zero = 1'b0;
`endif

   // State and output registers
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         tag_q        <= '0;
         REQ_READY    <= 1'b0;
         ALU_A        <= '0;
         ALU_B        <= '0;
         ALU_FUN      <= '0;
         Arith_Enable <= 1'b0;
         RSP_VALID    <= 1'b0;
         RSP_DATA     <= '0;
         RSP_CARRY    <= 1'b0;
         RSP_ERR      <= 1'b0;
         RSP_TAG      <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         tag_q        <= tag_d;
         REQ_READY    <= req_ready_d;
         ALU_A        <= alu_a_d;
         ALU_B        <= alu_b_d;
         ALU_FUN      <= alu_fun_d;
         Arith_Enable <= arith_enable_d;
         RSP_VALID    <= rsp_valid_d;
         RSP_DATA     <= rsp_data_d;
         RSP_CARRY    <= rsp_carry_d;
         RSP_ERR      <= rsp_err_d;
         RSP_TAG      <= rsp_tag_d;
      end
   end

   // Next state and wait counter
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = div_zero ? RESP : ISSUE;
            end
         end
         ISSUE: begin
            cnt_d   = CNT_LOAD;
            state_d = WAIT;
         end
         WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP: begin
            if (RSP_READY) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Next values of the registered outputs
   always_comb begin
      // Ready tracks the state being entered so it is already high in the first IDLE cycle.
      req_ready_d    = (state_d == IDLE);
      alu_a_d        = ALU_A;
      alu_b_d        = ALU_B;
      alu_fun_d      = ALU_FUN;
      arith_enable_d = 1'b0;
      tag_d          = tag_q;
      rsp_valid_d    = RSP_VALID;
      rsp_data_d     = RSP_DATA;
      rsp_carry_d    = RSP_CARRY;
      rsp_err_d      = RSP_ERR;
      rsp_tag_d      = RSP_TAG;

      unique case (state_q)
         IDLE: begin
            if (accept) begin
               alu_a_d   = REQ_A;
               alu_b_d   = REQ_B;
               alu_fun_d = {2'b00, REQ_OP};
               tag_d     = REQ_TAG;
               if (div_zero) begin
                  rsp_valid_d = 1'b1;
                  rsp_data_d  = '1;
                  rsp_carry_d = 1'b0;
                  rsp_err_d   = 1'b1;
                  rsp_tag_d   = REQ_TAG;
               end else begin
                  // Registered, so the strobe is high during the ISSUE cycle only.
                  arith_enable_d = 1'b1;
               end
            end
         end
         ISSUE: begin
         end
         WAIT: begin
            if (cnt_q == 4'd0) begin
               rsp_valid_d = 1'b1;
               rsp_data_d  = Arith_OUT;
               rsp_carry_d = Carry_OUT;
               rsp_err_d   = ~Arith_Flag;
               rsp_tag_d   = tag_q;
            end
         end
         RESP: begin
            if (RSP_READY) begin
               rsp_valid_d = 1'b0;
            end
         end
         default: begin
         end
      endcase
   end

endmodule
